// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if: start/data request and done/busy/line status between the UART slave and the transmitter
interface uart_tx_core_if;
  logic       TX_start;
  logic [7:0] TX_data;
  logic       TX_done;
  logic       TX_busy;
  logic       uart_TXD;
  modport master (output TX_start, TX_data, input TX_done, TX_busy, uart_TXD);
  modport slave  (input TX_start, TX_data, output TX_done, TX_busy, uart_TXD);
endinterface

// File: rtl/uart_tx_core.sv
// uart_tx_core: 8N1 UART transmitter, LSB first; define UART_TX_PARITY_EN for an 8E1/8O1 frame
module uart_tx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit PARITY_ODD   = 1'b0
) (
  input logic           clock,
  input logic           resetn,
  uart_tx_core_if.slave bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;
`endif
  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    idx, idx_d;
  logic [7:0]    sh, sh_d;
  logic          txd, txd_d, done, done_d;
  logic          last;
  assign last        = cnt == CW'(CLKS_PER_BIT - 1);
  assign bus.TX_busy = state != IDLE;
  assign bus.TX_done = done;
  assign bus.uart_TXD = txd;
  // state register; reset drives the line high immediately and aborts any frame
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_d;
  // datapath registers: baud counter, bit index, shift register, line and done pulse
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      cnt  <= '0;
      idx  <= '0;
      sh   <= '0;
      txd  <= 1'b1;
      done <= 1'b0;
    end else begin
      cnt  <= cnt_d;
      idx  <= idx_d;
      sh   <= sh_d;
      txd  <= txd_d;
      done <= done_d;
    end
  // next state and next line value, changing only at bit boundaries
  always_comb begin
    state_d = state;
    cnt_d   = last ? '0 : cnt + CW'(1);
    idx_d   = idx;
    sh_d    = sh;
    txd_d   = txd;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        cnt_d   = '0;
        state_d = bus.TX_start ? LOAD : IDLE;
      end
      LOAD: begin
        cnt_d   = '0;
        sh_d    = bus.TX_data;
        txd_d   = 1'b0;
        state_d = START;
      end
      START:
        if (last) begin
          idx_d   = '0;
          txd_d   = sh[0];
          state_d = DATA;
        end
      DATA:
        if (last && idx == 3'd7) begin
          idx_d = '0;
`ifdef UART_TX_PARITY_EN
          txd_d   = ^sh ^ PARITY_ODD;
          state_d = PARITY;
`else
          txd_d   = 1'b1 | PARITY_ODD;
          state_d = STOP;
`endif
        end else if (last) begin
          idx_d = idx + 3'd1;
          txd_d = sh[idx + 3'd1];
        end
`ifdef UART_TX_PARITY_EN
      PARITY:
        if (last) begin
          txd_d   = 1'b1;
          state_d = STOP;
        end
`endif
      STOP:
        if (last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: frame-level model compared every cycle, plus hand-computed timing/payload points
module tb_uart_tx_core;
  localparam int C = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam bit PODD = 1'b0;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int   cyc = 0;
  int   pass = 0;
  int   total = 0;
  uart_tx_core_if bus ();
  uart_tx_core #(.CLKS_PER_BIT(C), .PARITY_ODD(PODD)) dut (.clock(clock), .resetn(resetn), .bus(bus));
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask
  // model: one frame at a time; frame accepted at cycle fn, data taken in cycle fn+1
  bit         act = 1'b0;
  int         fn = 0;
  logic [7:0] fd = '0;
  function automatic logic frame_bit(int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return fd[k-1];
    if (k == 9 && NB == 11) return ^fd ^ PODD;
    return 1'b1;
  endfunction
  always @(negedge clock) begin
    logic ebusy, edone, etxd;
    if (!resetn) begin
      act = 1'b0;
      chk("rst_txd", {7'd0, bus.uart_TXD}, 8'd1);
      chk("rst_done", {7'd0, bus.TX_done}, 8'd0);
      chk("rst_busy", {7'd0, bus.TX_busy}, 8'd0);
    end else begin
      if (act && cyc == fn + 1) fd = bus.TX_data;
      ebusy = act && cyc >= fn + 1 && cyc < fn + 2 + NB * C;
      edone = act && cyc == fn + 2 + NB * C;
      etxd  = (act && cyc >= fn + 2 && cyc < fn + 2 + NB * C) ? frame_bit((cyc - fn - 2) / C) : 1'b1;
      chk("model_txd", {7'd0, bus.uart_TXD}, {7'd0, etxd});
      chk("model_done", {7'd0, bus.TX_done}, {7'd0, edone});
      chk("model_busy", {7'd0, bus.TX_busy}, {7'd0, ebusy});
      if (bus.TX_start && (!act || cyc >= fn + 2 + NB * C)) begin
        act = 1'b1;
        fn  = cyc;
      end
    end
  end
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic to_cycle(input int t);
    while (cyc < t) step();
  endtask
  task automatic sample_at(input int t);
    to_cycle(t);
    @(negedge clock);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, m;
    bus.TX_start = 1'b1;
    bus.TX_data  = 8'h00;
    repeat (4) step();
    @(negedge clock);
    chk("reset_txd", {7'd0, bus.uart_TXD}, 8'd1);
    chk("reset_busy", {7'd0, bus.TX_busy}, 8'd0);
    step();
    bus.TX_start = 1'b0;
    resetn = 1'b1;
    repeat (20) step();
    @(negedge clock);
    chk("post_reset_idle", {7'd0, bus.TX_busy}, 8'd0);
    // single byte 0x55
    step();
    bus.TX_start = 1'b1;
    n = cyc;
    step();
    bus.TX_start = 1'b0;
    bus.TX_data = 8'h55;
    step();
    bus.TX_data = 8'hFF;
    sample_at(n + 2);  chk("t2_start_first", {7'd0, bus.uart_TXD}, 8'd0);
    sample_at(n + 9);  chk("t2_start_last", {7'd0, bus.uart_TXD}, 8'd0);
    sample_at(n + 10); chk("t2_bit0", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(n + 18); chk("t2_bit1", {7'd0, bus.uart_TXD}, 8'd0);
    sample_at(n + 74); chk("t2_stop", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(n + 81); chk("t2_done_early", {7'd0, bus.TX_done}, 8'd0);
    // back-to-back 0xA3 requested in the done cycle
    to_cycle(n + 82);
    bus.TX_start = 1'b1;
    m = cyc;
    @(negedge clock);
    chk("t2_done", {7'd0, bus.TX_done}, 8'd1);
    step();
    bus.TX_start = 1'b0;
    bus.TX_data = 8'hA3;
    @(negedge clock);
    chk("t3_load_high", {7'd0, bus.uart_TXD}, 8'd1);
    step();
    bus.TX_data = 8'h00;
    @(negedge clock);
    chk("t3_start", {7'd0, bus.uart_TXD}, 8'd0);
    sample_at(m + 10); chk("t3_bit0", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(m + 26); chk("t3_bit2", {7'd0, bus.uart_TXD}, 8'd0);
    sample_at(m + 66); chk("t3_bit7", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(m + 82); chk("t3_done", {7'd0, bus.TX_done}, 8'd1);
    // busy ignore with 0x0F
    repeat (5) step();
    bus.TX_start = 1'b1;
    n = cyc;
    step();
    bus.TX_data = 8'h0F;
    step();
    bus.TX_start = 1'b0;
    to_cycle(n + 40);
    bus.TX_start = 1'b1;
    bus.TX_data = 8'hFF;
    step();
    bus.TX_start = 1'b0;
    sample_at(n + 42); chk("t4_bit4", {7'd0, bus.uart_TXD}, 8'd0);
    to_cycle(n + 81);
    bus.TX_start = 1'b1;
    step();
    bus.TX_start = 1'b0;
    @(negedge clock);
    chk("t4_done", {7'd0, bus.TX_done}, 8'd1);
    sample_at(n + 84); chk("t4_no_refire", {7'd0, bus.TX_busy}, 8'd0);
    // reset in bit 4 of 0x00
    repeat (3) step();
    bus.TX_start = 1'b1;
    n = cyc;
    step();
    bus.TX_start = 1'b0;
    bus.TX_data = 8'h00;
    sample_at(n + 44); chk("t5_low_before", {7'd0, bus.uart_TXD}, 8'd0);
    step();
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_async_txd", {7'd0, bus.uart_TXD}, 8'd1);
    chk("t5_async_busy", {7'd0, bus.TX_busy}, 8'd0);
    repeat (2) step();
    resetn = 1'b1;
    repeat (3) step();
    bus.TX_start = 1'b1;
    n = cyc;
    step();
    bus.TX_start = 1'b0;
    bus.TX_data = 8'hC5;
    sample_at(n + 10); chk("t5_bit0", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(n + 18); chk("t5_bit1", {7'd0, bus.uart_TXD}, 8'd0);
    sample_at(n + 2 + NB * C); chk("t5_done", {7'd0, bus.TX_done}, 8'd1);
`ifdef UART_TX_PARITY_EN
    repeat (3) step();
    bus.TX_start = 1'b1;
    n = cyc;
    step();
    bus.TX_start = 1'b0;
    bus.TX_data = 8'h07;
    sample_at(n + 74); chk("t6_parity", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(n + 82); chk("t6_stop", {7'd0, bus.uart_TXD}, 8'd1);
    sample_at(n + 90); chk("t6_done", {7'd0, bus.TX_done}, 8'd1);
`endif
    repeat (5) step();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
